// File: rtl/ex_div_ctrl_pkg.sv
// ex_div_ctrl_pkg: state encodings and shared constants for the EX-stage divide controller
package ex_div_ctrl_pkg;
   typedef enum logic [1:0] {
      DC_IDLE  = 2'd0,
      DC_BUSY  = 2'd1,
      DC_DONE  = 2'd2,
      DC_ABORT = 2'd3
   } dc_state_e;
   localparam logic        DIV_START     = 1'b1;
   localparam logic        DIV_STOP      = 1'b0;
   localparam logic        DIV_RES_READY = 1'b1;
   localparam logic        RST_ENABLE    = 1'b1;
   localparam logic [31:0] ZERO_WORD     = 32'h0;
   typedef struct packed {
      logic        sign;
      logic [31:0] op1;
      logic [31:0] op2;
   } div_req_t;
endpackage

// File: rtl/ex_div_ctrl_if.sv
// ex_div_ctrl_if: start/annul/operand/result handshake between EX control and the serial divider
interface ex_div_ctrl_if;
   logic        start;
   logic        annul;
   logic        sign;
   logic [31:0] op1;
   logic [31:0] op2;
   logic [63:0] result;
   logic        ready;
   modport master (output start, annul, sign, op1, op2, input result, ready);
   modport slave  (input start, annul, sign, op1, op2, output result, ready);
endinterface

// File: rtl/ex_div_ctrl.sv
// ex_div_ctrl: EX-stage divider initiator; stalls until HI/LO arrive, annuls cleanly on flush
module ex_div_ctrl
   import ex_div_ctrl_pkg::*;
#(
   parameter int DRAIN_CYC = 2,
   parameter int PERF_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              div_req_i,
   input  logic              div_signed_i,
   input  logic [31:0]       rs_i,
   input  logic [31:0]       rt_i,
   input  logic              flush_i,
   ex_div_ctrl_if.master     div_io,
   output logic              stall_o,
   output logic              hilo_we_o,
   output logic [31:0]       hi_o,
   output logic [31:0]       lo_o,
   output logic [PERF_W-1:0] busy_cnt_o
);
   localparam int DW = $clog2(DRAIN_CYC + 1);
   dc_state_e         state_q;
   div_req_t          lat_q;
   logic [DW-1:0]     drain_q;
   logic [PERF_W-1:0] busy_cnt_q;
   logic              busy, accept, abort, done_ok;
   assign busy    = state_q == DC_BUSY;
   assign accept  = state_q == DC_IDLE && div_req_i && !flush_i;
   assign abort   = busy && flush_i;
   assign done_ok = busy && div_io.ready == DIV_RES_READY && !flush_i;
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         state_q    <= DC_IDLE;
         lat_q      <= '0;
         drain_q    <= '0;
         busy_cnt_q <= '0;
      end else begin
         if (busy) busy_cnt_q <= busy_cnt_q + 1'b1;
         if (accept) lat_q <= {div_signed_i, rs_i, rt_i};
         unique case (state_q)
            DC_IDLE:  if (accept) state_q <= DC_BUSY;
            DC_BUSY: begin
               if (abort) begin
                  state_q <= DC_ABORT;
                  drain_q <= DW'(DRAIN_CYC - 1);
               end else if (done_ok) state_q <= DC_DONE;
            end
            DC_DONE:  state_q <= DC_IDLE;
            DC_ABORT: begin
               if (drain_q == '0) state_q <= DC_IDLE;
               else drain_q <= drain_q - 1'b1;
            end
         endcase
      end
   end
   // Operands come only from the latch so the divider's sign fix-up sees stable values.
   assign div_io.start = busy && !flush_i ? DIV_START : DIV_STOP;
   assign div_io.annul = abort;
   assign div_io.sign  = lat_q.sign;
   assign div_io.op1   = lat_q.op1;
   assign div_io.op2   = lat_q.op2;
   assign stall_o      = accept || (busy && !done_ok) || (state_q == DC_DONE && div_req_i && !flush_i);
   assign hilo_we_o    = done_ok;
   assign hi_o         = done_ok ? div_io.result[63:32] : ZERO_WORD;
   assign lo_o         = done_ok ? div_io.result[31:0] : ZERO_WORD;
   assign busy_cnt_o   = busy_cnt_q;
endmodule
